// File: rtl/inst_fetch_unit.sv
// Program-counter / fetch stage feeding the IF/ID register.
// Reads a word-addressed combinational instruction memory and honours stall/redirect.
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fetch_en,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_inst,
   output logic [31:0]        fetch_pc,
   output logic               ifid_valid,
   output logic [31:0]        ifid_pc,
   output logic [31:0]        ifid_pc4,
   output logic [31:0]        ifid_inst,
   output logic [15:0]        fetch_cnt,
   output logic               misalign_err
);

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] RUN  = 2'b01;
   localparam logic [1:0] HALT = 2'b10;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic [31:0] ipc_q, ipc_d;
   logic [31:0] ipc4_q, ipc4_d;
   logic [31:0] inst_q, inst_d;
   logic [15:0] cnt_q, cnt_d;
   logic        err_q, err_d;

   // Next-state: redirect beats stall, stall beats normal fetch; HALT is terminal
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      ipc_d   = ipc_q;
      ipc4_d  = ipc4_q;
      inst_d  = inst_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      if (state_q != HALT) begin
         if (redirect_valid) begin
            valid_d = 1'b0;
            if (redirect_pc[1:0] == 2'b00) begin
               pc_d = redirect_pc;
            end else begin
               state_d = HALT;
               err_d   = 1'b1;
            end
         end else if (state_q == IDLE) begin
            valid_d = 1'b0;
            if (fetch_en) state_d = RUN;
         end else if (!stall) begin
            if (fetch_en) begin
               inst_d  = imem_inst;
               ipc_d   = pc_q;
               ipc4_d  = pc_q + 32'd4;
               valid_d = 1'b1;
               pc_d    = pc_q + 32'd4;
               cnt_d   = cnt_q + 16'd1;
            end else begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         end
      end
   end

   // State and IF/ID registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         ipc_q   <= 32'd0;
         ipc4_q  <= 32'd0;
         inst_q  <= NOP;
         cnt_q   <= 16'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         ipc_q   <= ipc_d;
         ipc4_q  <= ipc4_d;
         inst_q  <= inst_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign imem_addr    = pc_q[IMEM_AW+1:2];
   assign fetch_pc     = pc_q;
   assign ifid_valid   = valid_q;
   assign ifid_pc      = ipc_q;
   assign ifid_pc4     = ipc4_q;
   assign ifid_inst    = inst_q;
   assign fetch_cnt    = cnt_q;
   assign misalign_err = err_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: directed spec scenarios followed by
// random stimulus checked against a behavioural fetch model.
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_en;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [4:0]  imem_addr;
   logic [31:0] imem_inst;
   logic [31:0] fetch_pc;
   logic        ifid_valid;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc4;
   logic [31:0] ifid_inst;
   logic [15:0] fetch_cnt;
   logic        misalign_err;

   logic [31:0] mem [32];
   int checks = 0;
   int errors = 0;

   // model state: mode 0=idle 1=run 2=halted
   int          m_mode;
   logic [31:0] m_pc, m_ipc, m_ipc4, m_inst;
   logic        m_v, m_err;
   logic [15:0] m_cnt;

   always #5 clk = ~clk;

   assign imem_inst = mem[imem_addr];

   inst_fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(5)) dut (
      .clk(clk), .rst(rst), .fetch_en(fetch_en), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_addr(imem_addr), .imem_inst(imem_inst),
      .fetch_pc(fetch_pc), .ifid_valid(ifid_valid),
      .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4), .ifid_inst(ifid_inst),
      .fetch_cnt(fetch_cnt), .misalign_err(misalign_err)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_pc = 32'h0; m_v = 1'b0;
      m_ipc = 32'h0; m_ipc4 = 32'h0; m_inst = 32'h13;
      m_cnt = 16'h0; m_err = 1'b0;
   endtask

   // behavioural rules of one clock edge
   task automatic model_step();
      if (m_mode == 2) return;
      if (redirect_valid) begin
         m_v = 1'b0;
         if (redirect_pc % 4 == 0) m_pc = redirect_pc;
         else begin m_mode = 2; m_err = 1'b1; end
      end else if (m_mode == 0) begin
         m_v = 1'b0;
         if (fetch_en) m_mode = 1;
      end else if (stall) begin
      end else if (fetch_en) begin
         m_inst = mem[(m_pc / 4) % 32];
         m_ipc  = m_pc;
         m_ipc4 = m_pc + 4;
         m_v    = 1'b1;
         m_pc   = m_pc + 4;
         m_cnt  = m_cnt + 1;
      end else begin
         m_mode = 0; m_v = 1'b0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pc"}, fetch_pc, m_pc);
      chk({tag, ".addr"}, {27'd0, imem_addr}, (m_pc / 4) % 32);
      chk({tag, ".v"}, {31'd0, ifid_valid}, {31'd0, m_v});
      chk({tag, ".ipc"}, ifid_pc, m_ipc);
      chk({tag, ".ipc4"}, ifid_pc4, m_ipc4);
      chk({tag, ".inst"}, ifid_inst, m_inst);
      chk({tag, ".cnt"}, {16'd0, fetch_cnt}, {16'd0, m_cnt});
      chk({tag, ".err"}, {31'd0, misalign_err}, {31'd0, m_err});
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      mem[0] = 32'h401180B3; mem[1] = 32'h00218133;
      mem[2] = 32'h001211B3; mem[8] = 32'h00A4F4B3;
      fetch_en = 1'b0; stall = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      rst = 1'b1;
      #2;
      model_reset();
      check_all("reset");
      chk("reset.nop", ifid_inst, 32'h0000_0013);
      @(negedge clk);
      rst = 1'b0;

      // 1: enter RUN then capture w0, w1
      fetch_en = 1'b1;
      tick("t1.run");
      tick("t1.c0");
      chk("t1.inst0", ifid_inst, 32'h401180B3);
      chk("t1.pc4_0", ifid_pc4, 32'h4);
      tick("t1.c1");
      chk("t1.inst1", ifid_inst, 32'h00218133);
      // 2: stall holds at ifid_pc=4
      stall = 1'b1;
      for (int i = 0; i < 3; i++) tick("t2.stall");
      chk("t2.pc_hold", fetch_pc, 32'h8);
      chk("t2.cnt_hold", {16'd0, fetch_cnt}, 32'd2);
      stall = 1'b0;
      tick("t2.rel");
      chk("t2.inst2", ifid_inst, 32'h001211B3);
      chk("t2.cnt3", {16'd0, fetch_cnt}, 32'd3);
      // 3: redirect under stall
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h20;
      tick("t3.redir");
      chk("t3.flush", {31'd0, ifid_valid}, 32'd0);
      chk("t3.pc", fetch_pc, 32'h20);
      stall = 1'b0; redirect_valid = 1'b0;
      tick("t3.cap");
      chk("t3.inst8", ifid_inst, 32'h00A4F4B3);
      // 4: misaligned redirect halts
      redirect_valid = 1'b1; redirect_pc = 32'h22;
      tick("t4.mis");
      chk("t4.err", {31'd0, misalign_err}, 32'd1);
      chk("t4.pc", fetch_pc, 32'h24);
      for (int i = 0; i < 10; i++) begin
         fetch_en = $urandom_range(0, 1);
         stall = $urandom_range(0, 1);
         redirect_valid = $urandom_range(0, 1);
         redirect_pc = $urandom & 32'hFC;
         tick("t4.frozen");
      end
      redirect_valid = 1'b0; stall = 1'b0; fetch_en = 1'b0;
      do_reset("t4.rst");
      // 5: alias wrap past end of memory
      fetch_en = 1'b1;
      tick("t5.run");
      redirect_valid = 1'b1; redirect_pc = 32'h7C;
      tick("t5.redir");
      chk("t5.addr31", {27'd0, imem_addr}, 32'd31);
      redirect_valid = 1'b0;
      tick("t5.c7c");
      chk("t5.addr0", {27'd0, imem_addr}, 32'd0);
      tick("t5.c80");
      chk("t5.ipc80", ifid_pc, 32'h80);
      chk("t5.alias", ifid_inst, 32'h401180B3);
      // 6: async reset mid-cycle
      tick("t6.run");
      #2;
      rst = 1'b1;
      #1;
      chk("t6.v", {31'd0, ifid_valid}, 32'd0);
      chk("t6.pc", fetch_pc, 32'h0);
      chk("t6.nop", ifid_inst, 32'h13);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_all("t6.after");

      // random phase
      for (int n = 0; n < 400; n++) begin
         fetch_en = ($urandom_range(0, 9) < 8);
         stall = ($urandom_range(0, 9) < 3);
         redirect_valid = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 7))
            0: redirect_pc = 32'hFFFF_FFF8;
            1: redirect_pc = $urandom;
            default: redirect_pc = $urandom & 32'h0000_03FC;
         endcase
         tick("rnd");
         if (m_mode == 2 && $urandom_range(0, 3) == 0) begin
            redirect_valid = 1'b0;
            do_reset("rnd.rst");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
